// File: rtl/key_cond_pkg.sv
// Shared constants and helpers for the key/switch input conditioner.
package key_cond_pkg;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW   = 10;

  // Default timing at 50 MHz: 10 ms debounce, 500 ms to first repeat, 100 ms repeat.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_EN       = 0;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Which interval the auto-repeat hold counter is timing.
  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } rep_phase_e;

  // Bits needed to hold a count up to max_count; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end else begin
      return $clog2(max_count + 1);
    end
  endfunction

  // Larger of two interval lengths, used to size a shared counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One pushbutton channel: 2-flop synchroniser, debounce counter, debounced
// level, one-cycle press pulse and optional auto-repeat while held.
module key_debounce_cell
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic pulse
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};

  logic            sync0_r;
  logic            sync1_r;
  logic            pressed_s;
  logic [DB_W-1:0] db_cnt_r;
  logic [DB_W-1:0] db_cnt_nxt_s;
  logic            accept_s;
  logic            rise_s;
  logic            level_r;
  logic            pulse_r;
  logic            rep_fire_s;

  // Two-flop synchroniser; reset value 1 means the key reads as released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0_r <= 1'b1;
      sync1_r <= 1'b1;
    end else begin
      sync0_r <= key_n;
      sync1_r <= sync0_r;
    end
  end

  assign pressed_s = ~sync1_r;

  // Count consecutive cycles the synchronised key disagrees with the accepted
  // level; accept the new value on the cycle the run reaches its full length.
  always_comb begin
    accept_s     = 1'b0;
    db_cnt_nxt_s = db_cnt_r;
    if (pressed_s == level_r) begin
      db_cnt_nxt_s = DB_ZERO;
    end else if (db_cnt_r == DB_TERM) begin
      accept_s     = 1'b1;
      db_cnt_nxt_s = DB_ZERO;
    end else begin
      db_cnt_nxt_s = db_cnt_r + DB_ONE;
    end
  end

  assign rise_s = accept_s & pressed_s;

  // Debounce counter, accepted level and registered press/repeat pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_r <= DB_ZERO;
      level_r  <= 1'b0;
      pulse_r  <= 1'b0;
    end else begin
      db_cnt_r <= db_cnt_nxt_s;
      level_r  <= accept_s ? pressed_s : level_r;
      pulse_r  <= rise_s | rep_fire_s;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam int                HOLD_W      = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
      localparam logic [HOLD_W-1:0] DELAY_TERM  = HOLD_W'(REPEAT_DELAY - 1);
      localparam logic [HOLD_W-1:0] PERIOD_TERM = HOLD_W'(REPEAT_PERIOD - 1);
      localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
      localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};

      logic [HOLD_W-1:0] hold_cnt_r;
      logic [HOLD_W-1:0] hold_term_s;
      rep_phase_e        phase_r;
      logic              fall_s;
      logic              fire_s;

      // Select the interval being timed: first repeat delay, then the period.
      always_comb begin
        case (phase_r)
          PH_DELAY:  hold_term_s = DELAY_TERM;
          PH_PERIOD: hold_term_s = PERIOD_TERM;
          default:   hold_term_s = DELAY_TERM;
        endcase
      end

      // A release accepted this cycle wins over a repeat due on the same edge.
      assign fall_s = accept_s & ~pressed_s;
      assign fire_s = level_r & ~fall_s & (hold_cnt_r == hold_term_s);

      // Hold counter runs only while the key is accepted as pressed and
      // restarts from zero after every repeat pulse.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hold_cnt_r <= HOLD_ZERO;
          phase_r    <= PH_DELAY;
        end else if (!level_r || fall_s) begin
          hold_cnt_r <= HOLD_ZERO;
          phase_r    <= PH_DELAY;
        end else if (fire_s) begin
          hold_cnt_r <= HOLD_ZERO;
          phase_r    <= PH_PERIOD;
        end else begin
          hold_cnt_r <= hold_cnt_r + HOLD_ONE;
          phase_r    <= phase_r;
        end
      end

      assign rep_fire_s = fire_s;
    end else begin : g_no_repeat
      assign rep_fire_s = 1'b0;
    end
  endgenerate

  assign level = level_r;
  assign pulse = pulse_r;

endmodule

// File: rtl/key_input_conditioner.sv
// Board input front end: synchronises the slide switches and runs one
// debounce/pulse cell per pushbutton.
module key_input_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_pulse_o,
  output logic [NUM_SW-1:0]   sw_sync_o
);

  logic [NUM_SW-1:0] sw_sync0_r;
  logic [NUM_SW-1:0] sw_sync1_r;

  // Two-flop switch synchroniser; switches are levels and are not debounced.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sw_sync0_r <= {NUM_SW{1'b0}};
      sw_sync1_r <= {NUM_SW{1'b0}};
    end else begin
      sw_sync0_r <= SW;
      sw_sync1_r <= sw_sync0_r;
    end
  end

  assign sw_sync_o = sw_sync1_r;

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (REPEAT_EN),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_cell (
        .clk  (CLOCK_50),
        .rst_n(RESET_N),
        .key_n(KEY[i]),
        .level(key_level_o[i]),
        .pulse(key_pulse_o[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: an edge-indexed behavioural model checked
// every cycle, plus directed scenarios with hand-computed edge numbers.
module tb_key_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [9:0] sw;
  logic [3:0] key_level_o;
  logic [3:0] key_pulse_o;
  logic [9:0] sw_sync_o;

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .KEY        (key),
    .SW         (sw),
    .key_level_o(key_level_o),
    .key_pulse_o(key_pulse_o),
    .sw_sync_o  (sw_sync_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: raw samples delayed two edges, accepted level, and for each
  // key the last edge where the seen value agreed with the level plus the
  // edge of the most recent accepted press.
  logic [3:0] m_d0 = 4'h0;
  logic [3:0] m_d1 = 4'h0;
  logic [3:0] m_level = 4'h0;
  logic [3:0] m_pulse = 4'h0;
  logic [9:0] m_sw0 = 10'h0;
  logic [9:0] m_sw1 = 10'h0;
  int last_agree [4];
  int press_edge [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic       old_lvl;
    logic       falling;
    int         k;
    if (!rst_n) begin
      m_d0 = 4'h0; m_d1 = 4'h0; m_level = 4'h0; m_pulse = 4'h0;
      m_sw0 = 10'h0; m_sw1 = 10'h0;
      for (int i = 0; i < 4; i++) last_agree[i] = cyc;
    end else begin
      s    = m_d1;
      m_d1 = m_d0;
      m_d0 = ~key;
      m_sw1 = m_sw0;
      m_sw0 = sw;
      for (int i = 0; i < 4; i++) begin
        old_lvl    = m_level[i];
        falling    = 1'b0;
        m_pulse[i] = 1'b0;
        if (s[i] == m_level[i]) begin
          last_agree[i] = cyc;
        end else if (cyc - last_agree[i] >= D) begin
          m_level[i]    = s[i];
          last_agree[i] = cyc;
          if (s[i]) begin
            m_pulse[i]    = 1'b1;
            press_edge[i] = cyc;
          end else begin
            falling = 1'b1;
          end
        end
        if (old_lvl && !falling) begin
          k = cyc - press_edge[i];
          if (k == RD || (k > RD && ((k - RD) % RP) == 0)) m_pulse[i] = 1'b1;
        end
      end
    end
  endtask

  // Compare process: advance the model on each rising edge, check #1 later.
  initial begin
    for (int i = 0; i < 4; i++) begin
      last_agree[i] = 0;
      press_edge[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      chk("model_level", {28'h0, key_level_o}, {28'h0, m_level});
      chk("model_pulse", {28'h0, key_pulse_o}, {28'h0, m_pulse});
      chk("model_sw",    {22'h0, sw_sync_o},   {22'h0, m_sw1});
    end
  end

  // Advance to the falling edge after rising edge number target.
  task automatic go_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at edge %0d: actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  int t, f, p, a;

  initial begin
    rst_n = 1'b0;
    key   = 4'h0;
    sw    = 10'h3FF;

    // Reset held for three edges with everything pressed / set.
    go_to(3);
    chk("rst_level", {28'h0, key_level_o}, 32'h0);
    chk("rst_pulse", {28'h0, key_pulse_o}, 32'h0);
    chk("rst_sw",    {22'h0, sw_sync_o},   32'h0);
    rst_n = 1'b1;
    key   = 4'hF;
    sw    = 10'h000;
    go_to(12);

    // Clean press of KEY[2].
    t = cyc;
    key[2] = 1'b0;
    go_to(t + 5);  chk("k2_pre_level", {28'h0, key_level_o}, 32'h0);
    go_to(t + 6);  chk("k2_level", {28'h0, key_level_o}, 32'h4);
                   chk("k2_pulse", {28'h0, key_pulse_o}, 32'h4);
    go_to(t + 7);  chk("k2_pulse_end", {28'h0, key_pulse_o}, 32'h0);
    go_to(t + 12); key[2] = 1'b1;
    go_to(t + 17); chk("k2_rel_hold", {28'h0, key_level_o}, 32'h4);
    go_to(t + 18); chk("k2_rel", {28'h0, key_level_o}, 32'h0);
                   chk("k2_rel_nopulse", {28'h0, key_pulse_o}, 32'h0);
    go_to(t + 22);

    // Bouncy press of KEY[0]: low2, high1, low3, high1, then hold.
    t = cyc;
    key[0] = 1'b0;
    go_to(t + 2);  key[0] = 1'b1;
    go_to(t + 3);  key[0] = 1'b0;
    go_to(t + 6);  key[0] = 1'b1;
    go_to(t + 7);  key[0] = 1'b0;
    f = t + 7;
    go_to(f + 5);  chk("k0_bounce_pre", {28'h0, key_level_o}, 32'h0);
    go_to(f + 6);  chk("k0_bounce_pulse", {28'h0, key_pulse_o}, 32'h1);
    go_to(f + 10); key[0] = 1'b1;
    go_to(f + 18);

    // Short glitch on KEY[1] must be discarded.
    t = cyc;
    key[1] = 1'b0;
    go_to(t + 3);  key[1] = 1'b1;
    go_to(t + 12); chk("k1_glitch", {28'h0, key_level_o}, 32'h0);

    // Simultaneous press of KEY[0] and KEY[1].
    t = cyc;
    key = 4'b1100;
    go_to(t + 6);  chk("sim_pulse", {28'h0, key_pulse_o}, 32'h3);
    go_to(t + 8);  key = 4'hF;
    go_to(t + 16);

    // Long hold of KEY[3] with auto-repeat.
    t = cyc;
    key[3] = 1'b0;
    p = t + 6;
    go_to(p);      chk("k3_press",  {28'h0, key_pulse_o}, 32'h8);
    go_to(p + 19); chk("k3_gap",    {28'h0, key_pulse_o}, 32'h0);
    go_to(p + 20); chk("k3_rep1",   {28'h0, key_pulse_o}, 32'h8);
    go_to(p + 27); chk("k3_gap2",   {28'h0, key_pulse_o}, 32'h0);
    go_to(p + 28); chk("k3_rep2",   {28'h0, key_pulse_o}, 32'h8);
    go_to(p + 36); chk("k3_rep3",   {28'h0, key_pulse_o}, 32'h8);
    go_to(t + 45); key[3] = 1'b1;
    go_to(t + 50); chk("k3_held",   {28'h0, key_level_o}, 32'h8);
    go_to(t + 51); chk("k3_rel",    {28'h0, key_level_o}, 32'h0);
    go_to(t + 60);

    // Reset while KEY[2] is held: one fresh press after reset release.
    t = cyc;
    key[2] = 1'b0;
    go_to(t + 10);
    a = cyc;
    rst_n = 1'b0;
    go_to(a + 1);  chk("mid_rst_level", {28'h0, key_level_o}, 32'h0);
                   chk("mid_rst_pulse", {28'h0, key_pulse_o}, 32'h0);
    go_to(a + 2);  rst_n = 1'b1;
    go_to(a + 7);  chk("post_rst_pre", {28'h0, key_level_o}, 32'h0);
    go_to(a + 8);  chk("post_rst_pulse", {28'h0, key_pulse_o}, 32'h4);
    go_to(a + 10); key = 4'hF;
    go_to(a + 20);

    // Switch synchroniser latency.
    t = cyc;
    sw = 10'd21;
    go_to(t + 1);  chk("sw_lat1", {22'h0, sw_sync_o}, 32'd0);
    go_to(t + 2);  chk("sw_21",   {22'h0, sw_sync_o}, 32'd21);
    sw = 10'd19;
    go_to(t + 3);  chk("sw_hold", {22'h0, sw_sync_o}, 32'd21);
    go_to(t + 4);  chk("sw_19",   {22'h0, sw_sync_o}, 32'd19);
    go_to(t + 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
